fetch_queue: RTL and testbench

- Instruction fetch front end that sits directly upstream of the single-cycle datapath.
- Generates sequential word addresses to instruction memory and holds at most one outstanding request.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them through a valid/ready interface.
- Accepts redirects (jump, jr, jal, taken branch) that flush queued and in-flight fetches.

---
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the single-cycle datapath.
// Issues sequential word fetches (one outstanding at most), buffers returned
// instructions with their PCs in a DEPTH-entry FIFO and hands them to the
// consumer over valid/ready. A redirect flushes the FIFO and any in-flight
// fetch and restarts fetching at the redirect target.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request and its word-aligned byte address
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid/imem_rdata   in-order response, >= 1 cycle after acceptance
//   redirect/redirect_pc     flush and restart at redirect_pc (bits [1:0] ignored)
//   out_valid/out_instr/out_pc  FIFO head
//   out_ready                consumer pops head when out_valid && out_ready
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [63:0]     mem_q [DEPTH];
   logic [63:0]     mem_d [DEPTH];
   // Registered copy of the FIFO head {instr, pc}; holds its value when empty.
   logic [63:0]     head_q, head_d;

   logic            accept;
   logic            push;
   logic            pop;

   assign imem_req  = !reset && (state_q == S_REQ) && !redirect && (count_q < DEPTH_C);
   assign imem_addr = fetch_pc_q;
   assign out_valid = !reset && (count_q != '0);
   assign out_instr = head_q[63:32];
   assign out_pc    = head_q[31:0];

   assign accept = imem_req && imem_ready;
   assign pop    = out_valid && out_ready && !redirect;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      mem_d      = mem_q;
      head_d     = head_q;
      push       = 1'b0;

      unique case (state_q)
         S_REQ: begin
            if (accept) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response arriving with a redirect is dropped; without one the
            // in-flight fetch must still be drained before issuing again.
            if (imem_rvalid) begin
               push    = !redirect;
               state_d = S_REQ;
            end else if (redirect) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {imem_rdata, req_pc_q};
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      // mem_d already contains this cycle's push, so a push into an empty
      // FIFO appears at the head the following cycle.
      if (count_d != '0) begin
         head_d = mem_d[rd_ptr_d];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         mem_q      <= '{default: '0};
         head_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
         head_q     <= head_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue.
// A memory responder answers each accepted fetch after a random latency; a
// transaction-level reference model (SV queues) predicts request, address and
// FIFO head every cycle.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // reference model: expected FIFO contents and fetch bookkeeping
   logic [31:0] q_pc[$];
   logic [31:0] q_ins[$];
   logic [31:0] m_fpc;
   logic [31:0] m_rpc;
   bit          m_out;
   bit          m_drop;

   // memory responder
   bit          mp;
   int unsigned mdly;
   logic [31:0] mdata;
   logic [31:0] acc_log[$];

   // stimulus knobs (percentages / max extra latency)
   int unsigned p_ready, p_oready, p_redir, max_lat;

   task automatic model_reset();
      q_pc.delete();
      q_ins.delete();
      m_fpc  = RPC;
      m_rpc  = '0;
      m_out  = 0;
      m_drop = 0;
      mp     = 0;
   endtask

   task automatic do_reset(input int unsigned n);
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      out_ready   = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         #1;
         check32("rst_req", {31'd0, imem_req}, 32'd0);
         check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
         @(posedge clock);
         #1;
      end
      check32("rst_out_pc", out_pc, 32'd0);
      check32("rst_out_instr", out_instr, 32'd0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic step();
      bit exp_req;
      redirect    = ($urandom_range(99) < p_redir);
      redirect_pc = $urandom;
      imem_ready  = ($urandom_range(99) < p_ready);
      out_ready   = ($urandom_range(99) < p_oready);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mp) begin
         if (mdly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mdata;
         end else begin
            mdly--;
         end
      end
      #1;
      exp_req = !m_out && !redirect && (q_pc.size() < DEPTH);
      check32("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) check32("imem_addr", imem_addr, m_fpc);
      check32("out_valid", {31'd0, out_valid}, {31'd0, q_pc.size() != 0});
      if (q_pc.size() != 0) begin
         check32("out_pc", out_pc, q_pc[0]);
         check32("out_instr", out_instr, q_ins[0]);
      end

      // memory environment reacts to what the DUT actually did
      if (imem_rvalid) mp = 0;
      if (imem_req && imem_ready) begin
         mp    = 1;
         mdly  = $urandom_range(max_lat);
         mdata = $urandom;
         acc_log.push_back(imem_addr);
      end

      // reference model update for this clock edge
      if (redirect) begin
         q_pc.delete();
         q_ins.delete();
         m_fpc = redirect_pc & 32'hFFFF_FFFC;
         if (m_out) begin
            if (imem_rvalid) m_out = 0;
            else m_drop = 1;
         end
      end else begin
         if (q_pc.size() != 0 && out_ready) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (m_out && imem_rvalid) begin
            if (!m_drop) begin
               q_pc.push_back(m_rpc);
               q_ins.push_back(imem_rdata);
            end
            m_out = 0;
         end else if (exp_req && imem_ready) begin
            m_rpc  = m_fpc;
            m_fpc  = m_fpc + 32'd4;
            m_out  = 1;
            m_drop = 0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      out_ready   = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
      do_reset(3);

      // back-to-back fetch across the 32-bit address wrap
      p_ready = 100; p_oready = 100; p_redir = 0; max_lat = 0;
      acc_log.delete();
      for (int i = 0; i < 12; i++) step();
      check32("accepts_in_12", 32'(acc_log.size()), 32'd6);
      if (acc_log.size() >= 3) begin
         check32("addr0", acc_log[0], 32'hFFFF_FFF8);
         check32("addr1", acc_log[1], 32'hFFFF_FFFC);
         check32("addr2", acc_log[2], 32'h0000_0000);
      end

      // consumer stalled: FIFO fills and issue stops
      p_oready = 0;
      for (int i = 0; i < 20; i++) step();
      check32("full_level", 32'(q_pc.size()), 32'(DEPTH));
      check32("full_valid", {31'd0, out_valid}, 32'd1);

      // random traffic with redirects and occasional resets
      p_ready = 60; p_oready = 50; p_redir = 8; max_lat = 3;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 1000; i++) step();
         do_reset(2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
